// File: rtl/game_flow_ctl.sv
// Frame-synchronous screen sequencer (IDLE/WAIT/GAME/SCORE) with round timer and BCD scores.
// Screen changes are applied only on the rising edge of vertical blank.
module game_flow_ctl #(
  parameter int ROUND_FRAMES = 1800,
  parameter int SCORE_FRAMES = 300,
  parameter int WAIT_FRAMES  = 3600
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        rect_clicked_play,
  input  logic        uart_start,
  input  logic        mouse_clicked_stop,
  input  logic        my_hit,
  input  logic        op_hit,
  output logic [1:0]  state,
  output logic        state_changed,
  output logic        uart_req,
  output logic [11:0] frames_left,
  output logic [15:0] my_score,
  output logic [15:0] op_score
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_GAME  = 2'd2,
    S_SCORE = 2'd3
  } state_e;

  localparam logic [11:0] ROUND_LD = 12'(ROUND_FRAMES);
  localparam logic [11:0] SCORE_LD = 12'(SCORE_FRAMES);
  localparam logic [11:0] WAIT_LD  = 12'(WAIT_FRAMES);

  // Saturating 4-digit BCD increment; 9999 is sticky.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (carry == 1'b1) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [11:0] frames_q, frames_d;
  logic [15:0] my_q, my_d;
  logic [15:0] op_q, op_d;
  logic        changed_q, changed_d;
  logic        uart_req_q, uart_req_d;
  logic        vblnk_q;
  logic        click_q, click_d;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
  logic        frame_tick;
  logic        click_now, start_now, stop_now;
  logic        clear_scores;

  assign frame_tick = vblnk_in & ~vblnk_q;
  // A pulse arriving in the tick cycle itself is folded into that tick's decision.
  assign click_now  = click_q | rect_clicked_play;
  assign start_now  = start_q | uart_start;
  assign stop_now   = stop_q | mouse_clicked_stop;

  // Sticky event flags, cleared once each tick has consumed them.
  always_comb begin
    click_d = click_q;
    start_d = start_q;
    stop_d  = stop_q;
    if (frame_tick) begin
      click_d = 1'b0;
      start_d = 1'b0;
      stop_d  = 1'b0;
    end else begin
      click_d = click_now;
      start_d = start_now;
      stop_d  = stop_now;
    end
  end

  // Screen transitions and frame countdown, only on a frame tick.
  always_comb begin
    state_d      = state_q;
    frames_d     = frames_q;
    uart_req_d   = 1'b0;
    clear_scores = 1'b0;
    if (frame_tick) begin
      case (state_q)
        S_IDLE: begin
          if (click_now) begin
            state_d    = S_WAIT;
            frames_d   = WAIT_LD;
            uart_req_d = 1'b1;
          end else begin
            frames_d = 12'd0;
          end
        end
        S_WAIT: begin
          if (stop_now) begin
            state_d  = S_IDLE;
            frames_d = 12'd0;
          end else if (start_now) begin
            state_d      = S_GAME;
            frames_d     = ROUND_LD;
            clear_scores = 1'b1;
          end else if (frames_q == 12'd1) begin
            state_d  = S_IDLE;
            frames_d = 12'd0;
          end else begin
            frames_d = frames_q - 12'd1;
          end
        end
        S_GAME: begin
          if (stop_now || (frames_q == 12'd1)) begin
            state_d  = S_SCORE;
            frames_d = SCORE_LD;
          end else begin
            frames_d = frames_q - 12'd1;
          end
        end
        S_SCORE: begin
          if (click_now || (frames_q == 12'd1)) begin
            state_d  = S_IDLE;
            frames_d = 12'd0;
          end else begin
            frames_d = frames_q - 12'd1;
          end
        end
        default: begin
          state_d  = S_IDLE;
          frames_d = 12'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    changed_d = (state_d != state_q);
  end

  // Hits count on any cycle while in GAME; entry to GAME clears both counters.
  always_comb begin
    my_d = my_q;
    op_d = op_q;
    if (clear_scores) begin
      my_d = 16'h0000;
      op_d = 16'h0000;
    end else if (state_q == S_GAME) begin
      if (my_hit) begin
        my_d = bcd_inc(my_q);
      end else begin
        my_d = my_q;
      end
      if (op_hit) begin
        op_d = bcd_inc(op_q);
      end else begin
        op_d = op_q;
      end
    end else begin
      my_d = my_q;
      op_d = op_q;
    end
  end

  // State, timer, score and pulse registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frames_q   <= 12'd0;
      my_q       <= 16'h0000;
      op_q       <= 16'h0000;
      changed_q  <= 1'b0;
      uart_req_q <= 1'b0;
      vblnk_q    <= 1'b0;
      click_q    <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frames_q   <= frames_d;
      my_q       <= my_d;
      op_q       <= op_d;
      changed_q  <= changed_d;
      uart_req_q <= uart_req_d;
      vblnk_q    <= vblnk_in;
      click_q    <= click_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign state         = state_q;
  assign state_changed = changed_q;
  assign uart_req      = uart_req_q;
  assign frames_left   = frames_q;
  assign my_score      = my_q;
  assign op_score      = op_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Scoreboard bench for game_flow_ctl: expected screen entries are queued by the stimulus
// and checked by a monitor whenever state_changed or uart_req pulses.
module tb_game_flow_ctl;

  localparam int RF = 3;
  localparam int SF = 5;
  localparam int WF = 3600;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk_in = 1'b0;
  logic        rect_clicked_play = 1'b0;
  logic        uart_start = 1'b0;
  logic        mouse_clicked_stop = 1'b0;
  logic        my_hit = 1'b0;
  logic        op_hit = 1'b0;
  logic [1:0]  state;
  logic        state_changed;
  logic        uart_req;
  logic [11:0] frames_left;
  logic [15:0] my_score;
  logic [15:0] op_score;

  int total = 0;
  int bad = 0;

  logic [46:0] exp_q[$];
  string       name_q[$];

  game_flow_ctl #(.ROUND_FRAMES(RF), .SCORE_FRAMES(SF), .WAIT_FRAMES(WF)) dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in),
    .rect_clicked_play(rect_clicked_play), .uart_start(uart_start),
    .mouse_clicked_stop(mouse_clicked_stop), .my_hit(my_hit), .op_hit(op_hit),
    .state(state), .state_changed(state_changed), .uart_req(uart_req),
    .frames_left(frames_left), .my_score(my_score), .op_score(op_score)
  );

  always #5 pclk = ~pclk;

  function automatic logic [46:0] mk(input logic [1:0] s, input logic [11:0] f,
                                     input logic [15:0] m, input logic [15:0] o, input logic u);
    return {s, f, m, o, u};
  endfunction

  task automatic expect_entry(input string nm, input logic [46:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every state_changed/uart_req pulse must match the oldest queued entry.
  always @(negedge pclk) begin
    logic [46:0] act;
    logic [46:0] e;
    string       nm;
    if (!rst && (state_changed || uart_req)) begin
      act = {state, frames_left, my_score, op_score, uart_req};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change: got %h expected no event", act);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (!state_changed || act !== e) begin
          bad++;
          $display("FAIL %s: got %h (chg=%0b) expected %h", nm, act, state_changed, e);
        end
      end
    end
  end

  // One frame: low phase, then a vblnk rise (the tick) and a short high phase.
  task automatic frame();
    repeat (6) @(negedge pclk);
    vblnk_in = 1'b1;
    repeat (4) @(negedge pclk);
    vblnk_in = 1'b0;
  endtask

  task automatic pulse_click();
    rect_clicked_play = 1'b1; @(negedge pclk); rect_clicked_play = 1'b0; @(negedge pclk);
  endtask
  task automatic pulse_start();
    uart_start = 1'b1; @(negedge pclk); uart_start = 1'b0; @(negedge pclk);
  endtask
  task automatic pulse_stop();
    mouse_clicked_stop = 1'b1; @(negedge pclk); mouse_clicked_stop = 1'b0; @(negedge pclk);
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    check("reset_values", {state, frames_left, my_score, op_score, state_changed, uart_req}, 64'd0);

    repeat (3) frame();
    check("idle_after_3_frames", {state, frames_left, my_score, op_score}, 64'd0);

    // IDLE -> WAIT on a mid-frame click
    repeat (3) @(negedge pclk);
    pulse_click();
    expect_entry("enter_wait", mk(2'd1, 12'd3600, 16'h0000, 16'h0000, 1'b1));
    frame();
    frame();
    check("wait_countdown", {state, frames_left}, {2'd1, 12'd3599});

    // WAIT -> GAME, then hits
    pulse_start();
    expect_entry("enter_game", mk(2'd2, 12'd3, 16'h0000, 16'h0000, 1'b0));
    frame();
    for (int i = 0; i < 12; i++) begin
      my_hit = 1'b1; @(negedge pclk); my_hit = 1'b0; @(negedge pclk);
    end
    op_hit = 1'b1; @(negedge pclk); op_hit = 1'b0; @(negedge pclk);
    check("game_scores", {my_score, op_score}, {16'h0012, 16'h0001});
    frame();
    frame();
    expect_entry("round_end_score", mk(2'd3, 12'd5, 16'h0012, 16'h0001, 1'b0));
    frame();

    // Hits in SCORE are ignored; click returns to IDLE with scores held
    my_hit = 1'b1; @(negedge pclk); my_hit = 1'b0; @(negedge pclk);
    pulse_click();
    expect_entry("score_click_idle", mk(2'd0, 12'd0, 16'h0012, 16'h0001, 1'b0));
    frame();

    // Second round: scores clear on GAME entry, then saturate at 9999
    pulse_click();
    expect_entry("enter_wait2", mk(2'd1, 12'd3600, 16'h0012, 16'h0001, 1'b1));
    frame();
    pulse_start();
    expect_entry("enter_game2", mk(2'd2, 12'd3, 16'h0000, 16'h0000, 1'b0));
    frame();
    my_hit = 1'b1;
    repeat (9999) @(negedge pclk);
    check("score_reaches_9999", {48'd0, my_score}, {48'd0, 16'h9999});
    op_hit = 1'b1;
    @(negedge pclk);
    my_hit = 1'b0;
    op_hit = 1'b0;
    @(negedge pclk);
    check("score_saturated", {my_score, op_score}, {16'h9999, 16'h0001});
    frame();
    frame();
    expect_entry("round_end_score2", mk(2'd3, 12'd5, 16'h9999, 16'h0001, 1'b0));
    frame();
    repeat (4) frame();
    check("score_countdown", {state, frames_left}, {2'd3, 12'd1});
    expect_entry("score_timeout_idle", mk(2'd0, 12'd0, 16'h9999, 16'h0001, 1'b0));
    frame();

    // WAIT with stop, click and uart_start in one frame: stop wins
    pulse_click();
    expect_entry("enter_wait3", mk(2'd1, 12'd3600, 16'h9999, 16'h0001, 1'b1));
    frame();
    pulse_start();
    pulse_stop();
    pulse_click();
    expect_entry("stop_wins_idle", mk(2'd0, 12'd0, 16'h9999, 16'h0001, 1'b0));
    frame();

    // Click in the tick cycle itself; uart_start while vblnk stays high waits for the next rise
    repeat (6) @(negedge pclk);
    expect_entry("click_on_tick", mk(2'd1, 12'd3600, 16'h9999, 16'h0001, 1'b1));
    vblnk_in = 1'b1;
    rect_clicked_play = 1'b1;
    @(negedge pclk);
    rect_clicked_play = 1'b0;
    pulse_start();
    repeat (2) @(negedge pclk);
    vblnk_in = 1'b0;
    check("start_held_until_next_tick", {state, frames_left}, {2'd1, 12'd3600});
    expect_entry("enter_game3", mk(2'd2, 12'd3, 16'h0000, 16'h0000, 1'b0));
    frame();

    // Asynchronous reset mid-GAME with a coincident hit
    for (int i = 0; i < 3; i++) begin
      my_hit = 1'b1; @(negedge pclk); my_hit = 1'b0; @(negedge pclk);
    end
    check("pre_reset_score", {48'd0, my_score}, {48'd0, 16'h0003});
    rst = 1'b1;
    my_hit = 1'b1;
    #1;
    check("async_reset", {state, frames_left, my_score, op_score, state_changed, uart_req}, 64'd0);
    @(negedge pclk);
    check("reset_hold", {state, frames_left, my_score, op_score, state_changed, uart_req}, 64'd0);
    my_hit = 1'b0;
    rst = 1'b0;
    repeat (2) frame();
    check("idle_after_reset", {state, frames_left, my_score}, 64'd0);
    check("all_entries_seen", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
